// File: rtl/cache_pkg.sv
// Shared types and constants for the CPU-side request generator.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    NEXT,
    FIN
  } cpu_req_gen_state_t;

  localparam logic [1:0] MODE_SEQ     = 2'd0;
  localparam logic [1:0] MODE_RAND_RD = 2'd1;
  localparam logic [1:0] MODE_RAND_RW = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // An all-zero state would lock the LFSR, so it is replaced by the default seed.
  function automatic logic [15:0] lfsr_fix_seed(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/cpu_req_lfsr16.sv
// 16-bit Galois LFSR used for random addresses, op selection and write data.
module cpu_req_lfsr16
  import cache_pkg::*;
#(
  parameter logic [15:0] RST_SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = lfsr_fix_seed(seed);
    end else if (step) begin
      q_d = q_q[0] ? ((q_q >> 1) ^ LFSR_TAPS) : (q_q >> 1);
    end
  end

  // rst_n is active-high in this codebase.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      q_q <= lfsr_fix_seed(RST_SEED);
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cpu_req_gen.sv
// CPU-side traffic generator: issues NUM_REQS requests to L1 and gathers hit/latency statistics.
module cpu_req_gen
  import cache_pkg::*;
#(
  parameter int          ADDR_WIDTH = 11,
  parameter int          DATA_WIDTH = 8,
  parameter int          NUM_REQS   = 10000,
  parameter int          REQ_CYCLES = 2,
  parameter int          TIMEOUT    = 1023,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic                  cpu_read,
  output logic                  cpu_write,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  input  logic                  cpu_ready,
  input  logic                  l1_hit,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic [CNT_WIDTH-1:0]  req_count,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  cycle_total,
  output logic [DATA_WIDTH-1:0] last_rdata
);

  // Latency counter spans REQ plus WAIT; its value also drives the REQ length and timeout.
  localparam int LAT_W = $clog2(REQ_CYCLES + TIMEOUT + 1);
  localparam logic [LAT_W-1:0] REQ_LAST  = LAT_W'(REQ_CYCLES - 1);
  localparam logic [LAT_W-1:0] WAIT_LAST = LAT_W'(REQ_CYCLES + TIMEOUT - 1);

  cpu_req_gen_state_t    state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] rcap_q, rcap_d;
  logic [CNT_WIDTH-1:0]  req_count_q, req_count_d;
  logic [CNT_WIDTH-1:0]  hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0]  cycle_total_q, cycle_total_d;
  logic [DATA_WIDTH-1:0] last_rdata_q, last_rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [15:0]           lfsr_q;
  logic                  lfsr_step;
  logic                  is_write;
  logic                  in_req;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [CNT_WIDTH-1:0]  req_next;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [LAT_W-1:0]     b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH + 1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  cpu_req_lfsr16 #(
    .RST_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (1'b0),
    .seed (LFSR_SEED),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  // Address and op only move in NEXT, so they are stable across the whole REQ phase.
  assign is_write = (mode_q == MODE_RAND_RW) && lfsr_q[15];
  assign req_addr = (mode_q == MODE_SEQ) ? addr_cnt_q : lfsr_q[ADDR_WIDTH-1:0];
  assign in_req   = (state_q == REQ);
  assign req_next = req_count_q + 1'b1;

  assign cpu_read    = in_req && !is_write;
  assign cpu_write   = in_req && is_write;
  assign cpu_addr    = in_req ? req_addr : '0;
  assign cpu_data_in = (in_req && is_write) ? DATA_WIDTH'(lfsr_q[7:0]) : '0;

  assign busy        = (state_q == REQ) || (state_q == WAIT) || (state_q == NEXT);
  assign done        = done_q;
  assign err_timeout = err_q;
  assign req_count   = req_count_q;
  assign hit_count   = hit_count_q;
  assign cycle_total = cycle_total_q;
  assign last_rdata  = last_rdata_q;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    addr_cnt_d    = addr_cnt_q;
    lat_d         = lat_q;
    hit_d         = hit_q;
    rcap_d        = rcap_q;
    req_count_d   = req_count_q;
    hit_count_d   = hit_count_q;
    cycle_total_d = cycle_total_q;
    last_rdata_d  = last_rdata_q;
    done_d        = done_q;
    err_d         = err_q;
    lfsr_step     = 1'b0;

    unique case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d       = REQ;
          mode_d        = mode;
          addr_cnt_d    = '0;
          lat_d         = '0;
          req_count_d   = '0;
          hit_count_d   = '0;
          cycle_total_d = '0;
          done_d        = 1'b0;
          err_d         = 1'b0;
        end
      end
      REQ: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == REQ_LAST) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        lat_d = lat_q + 1'b1;
        if (cpu_ready) begin
          state_d = NEXT;
          hit_d   = l1_hit;
          rcap_d  = cpu_data_out;
        end else if (lat_q == WAIT_LAST) begin
          state_d = FIN;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      NEXT: begin
        req_count_d   = req_next;
        hit_count_d   = hit_count_q + CNT_WIDTH'(hit_q);
        cycle_total_d = sat_add(cycle_total_q, lat_q);
        if (!is_write) begin
          last_rdata_d = rcap_q;
        end
        lfsr_step  = 1'b1;
        addr_cnt_d = addr_cnt_q + 1'b1;
        lat_d      = '0;
        if (req_next < CNT_WIDTH'(NUM_REQS)) begin
          state_d = REQ;
        end else begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= IDLE;
      mode_q        <= MODE_SEQ;
      addr_cnt_q    <= '0;
      lat_q         <= '0;
      hit_q         <= 1'b0;
      rcap_q        <= '0;
      req_count_q   <= '0;
      hit_count_q   <= '0;
      cycle_total_q <= '0;
      last_rdata_q  <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      addr_cnt_q    <= addr_cnt_d;
      lat_q         <= lat_d;
      hit_q         <= hit_d;
      rcap_q        <= rcap_d;
      req_count_q   <= req_count_d;
      hit_count_q   <= hit_count_d;
      cycle_total_q <= cycle_total_d;
      last_rdata_q  <= last_rdata_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

endmodule
